alu_issue: RTL and testbench

Two-stage issue/retire wrapper that sits directly upstream and downstream of the 16-bit ALU datapath. It accepts operations over a valid/ready handshake and decodes a 3-bit function code into the 5-bit ALU control word `{inva, invb, ci, op[1:0]}`. It holds operands stable on the ALU inputs for one cycle, then captures result, overflow and zero into an output register with its own valid/ready handshake. Full throughput (one op per cycle) under no back-pressure.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_decode.sv | 24 ++
 rtl/alu_issue.sv | 157 +++++++++++++++
 tb/tb_alu_issue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue/retire wrapper: function codes,
// ALU control words and the layout of the control word fields.
package alu_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned FUNC_W  = 3;
   localparam int unsigned ALUOP_W = 5;

   // Field positions inside the ALU control word {inva, invb, ci, op[1:0]}
   localparam int unsigned INVA_BIT = 4;
   localparam int unsigned INVB_BIT = 3;
   localparam int unsigned CI_BIT   = 2;
   localparam int unsigned OP_HI    = 1;
   localparam int unsigned OP_LO    = 0;

   localparam logic [FUNC_W-1:0] FN_AND  = 3'b000;
   localparam logic [FUNC_W-1:0] FN_OR   = 3'b001;
   localparam logic [FUNC_W-1:0] FN_ADD  = 3'b010;
   localparam logic [FUNC_W-1:0] FN_SUB  = 3'b011;
   localparam logic [FUNC_W-1:0] FN_SLT  = 3'b100;
   localparam logic [FUNC_W-1:0] FN_NOR  = 3'b101;
   localparam logic [FUNC_W-1:0] FN_NAND = 3'b110;
   localparam logic [FUNC_W-1:0] FN_RSVD = 3'b111;

   localparam logic [ALUOP_W-1:0] ALUOP_AND  = 5'b00000;
   localparam logic [ALUOP_W-1:0] ALUOP_OR   = 5'b00001;
   localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 5'b00010;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 5'b01110;
   localparam logic [ALUOP_W-1:0] ALUOP_SLT  = 5'b01111;
   localparam logic [ALUOP_W-1:0] ALUOP_NOR  = 5'b11000;
   localparam logic [ALUOP_W-1:0] ALUOP_NAND = 5'b11001;

   typedef struct packed {
      logic [ALUOP_W-1:0] aluop;
      logic               illegal;
      logic               is_arith;
   } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of a function code into the ALU control word plus
// the illegal and arithmetic (overflow-meaningful) flags.
module alu_decode
   import alu_pkg::*;
(
   input  logic [FUNC_W-1:0] func_i,
   output dec_t              dec_c_o
);

   always_comb begin
      dec_c_o = '{aluop: ALUOP_AND, illegal: 1'b0, is_arith: 1'b0};
      case (func_i)
         FN_AND:  dec_c_o.aluop = ALUOP_AND;
         FN_OR:   dec_c_o.aluop = ALUOP_OR;
         FN_ADD:  dec_c_o = '{aluop: ALUOP_ADD, illegal: 1'b0, is_arith: 1'b1};
         FN_SUB:  dec_c_o = '{aluop: ALUOP_SUB, illegal: 1'b0, is_arith: 1'b1};
         FN_SLT:  dec_c_o.aluop = ALUOP_SLT;
         FN_NOR:  dec_c_o.aluop = ALUOP_NOR;
         FN_NAND: dec_c_o.aluop = ALUOP_NAND;
         default: dec_c_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue/retire wrapper around the external 16-bit ALU: an op
// register driving the ALU inputs and a result register with its own handshake.
module alu_issue
   import alu_pkg::*;
#(
   parameter int unsigned TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [FUNC_W-1:0]  in_func,
   input  logic [DATA_W-1:0]  in_a,
   input  logic [DATA_W-1:0]  in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic [ALUOP_W-1:0] alu_aluop,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic               alu_ovf,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_result,
   output logic               out_ovf,
   output logic               out_zero,
   output logic               out_illegal,
   output logic [TAG_W-1:0]   out_tag,
   output logic               ovf_sticky,
   input  logic               ovf_clr
);

   dec_t dec;

   logic               op_valid_q, op_valid_d;
   logic [ALUOP_W-1:0] aluop_q, aluop_d;
   logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               illegal_q, illegal_d;
   logic               is_arith_q, is_arith_d;

   logic               res_valid_q, res_valid_d;
   logic [DATA_W-1:0]  result_q, result_d;
   logic               ovf_q, ovf_d;
   logic               zero_q, zero_d;
   logic               res_illegal_q, res_illegal_d;
   logic [TAG_W-1:0]   res_tag_q, res_tag_d;
   logic               sticky_q, sticky_d;

   logic res_load;
   logic in_fire;

   alu_decode u_decode (
      .func_i  (in_func),
      .dec_c_o (dec)
   );

   // Stage 2 advances when empty or draining; stage 1 may refill behind it.
   assign res_load = op_valid_q && (!res_valid_q || out_ready);
   assign in_ready = !op_valid_q || res_load;
   assign in_fire  = in_valid && in_ready;

   always_comb begin
      op_valid_d = op_valid_q;
      aluop_d    = aluop_q;
      a_d        = a_q;
      b_d        = b_q;
      tag_d      = tag_q;
      illegal_d  = illegal_q;
      is_arith_d = is_arith_q;
      if (in_fire) begin
         op_valid_d = 1'b1;
         aluop_d    = dec.aluop;
         a_d        = in_a;
         b_d        = in_b;
         tag_d      = in_tag;
         illegal_d  = dec.illegal;
         is_arith_d = dec.is_arith;
      end else if (res_load) begin
         op_valid_d = 1'b0;
      end
   end

   always_comb begin
      res_valid_d   = res_valid_q;
      result_d      = result_q;
      ovf_d         = ovf_q;
      zero_d        = zero_q;
      res_illegal_d = res_illegal_q;
      res_tag_d     = res_tag_q;
      if (res_load) begin
         res_valid_d   = 1'b1;
         result_d      = alu_result;
         ovf_d         = alu_ovf && is_arith_q;
         zero_d        = (alu_result == '0);
         res_illegal_d = illegal_q;
         res_tag_d     = tag_q;
      end else if (res_valid_q && out_ready) begin
         res_valid_d = 1'b0;
      end
   end

   // Clear takes priority over a same-cycle overflow retire.
   always_comb begin
      sticky_d = sticky_q;
      if (ovf_clr) begin
         sticky_d = 1'b0;
      end else if (res_load && alu_ovf && is_arith_q) begin
         sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_valid_q    <= 1'b0;
         aluop_q       <= '0;
         a_q           <= '0;
         b_q           <= '0;
         tag_q         <= '0;
         illegal_q     <= 1'b0;
         is_arith_q    <= 1'b0;
         res_valid_q   <= 1'b0;
         result_q      <= '0;
         ovf_q         <= 1'b0;
         zero_q        <= 1'b0;
         res_illegal_q <= 1'b0;
         res_tag_q     <= '0;
         sticky_q      <= 1'b0;
      end else begin
         op_valid_q    <= op_valid_d;
         aluop_q       <= aluop_d;
         a_q           <= a_d;
         b_q           <= b_d;
         tag_q         <= tag_d;
         illegal_q     <= illegal_d;
         is_arith_q    <= is_arith_d;
         res_valid_q   <= res_valid_d;
         result_q      <= result_d;
         ovf_q         <= ovf_d;
         zero_q        <= zero_d;
         res_illegal_q <= res_illegal_d;
         res_tag_q     <= res_tag_d;
         sticky_q      <= sticky_d;
      end
   end

   assign alu_aluop   = aluop_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign out_valid   = res_valid_q;
   assign out_result  = result_q;
   assign out_ovf     = ovf_q;
   assign out_zero    = zero_q;
   assign out_illegal = res_illegal_q;
   assign out_tag     = res_tag_q;
   assign ovf_sticky  = sticky_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a behavioural 16-bit ALU closing the
// loop between alu_* outputs and alu_result/alu_ovf inputs.
module tb_alu_issue;
   import alu_pkg::*;

   localparam int unsigned TAG_W = 4;

   logic               clk, rst_n;
   logic               in_valid, in_ready;
   logic [2:0]         in_func;
   logic [15:0]        in_a, in_b;
   logic [TAG_W-1:0]   in_tag;
   logic [4:0]         alu_aluop;
   logic [15:0]        alu_a, alu_b, alu_result;
   logic               alu_ovf;
   logic               out_valid, out_ready;
   logic [15:0]        out_result;
   logic               out_ovf, out_zero, out_illegal;
   logic [TAG_W-1:0]   out_tag;
   logic               ovf_sticky, ovf_clr;

   alu_issue #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .alu_aluop(alu_aluop), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_ovf(alu_ovf),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_ovf(out_ovf), .out_zero(out_zero), .out_illegal(out_illegal),
      .out_tag(out_tag), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: optional inversions, carry-in, then AND/OR/ADD/SLT.
   logic [15:0] am, bm, sum;
   logic        add_ovf;
   always_comb begin
      am      = alu_aluop[INVA_BIT] ? ~alu_a : alu_a;
      bm      = alu_aluop[INVB_BIT] ? ~alu_b : alu_b;
      sum     = am + bm + {15'd0, alu_aluop[CI_BIT]};
      add_ovf = (am[15] == bm[15]) && (sum[15] != am[15]);
      case (alu_aluop[OP_HI:OP_LO])
         2'b00:   alu_result = am & bm;
         2'b01:   alu_result = am | bm;
         2'b10:   alu_result = sum;
         default: alu_result = {15'd0, sum[15] ^ add_ovf};
      endcase
      alu_ovf = add_ovf;
   end

   typedef struct packed {
      logic [15:0]      res;
      logic             ovf;
      logic             zero;
      logic             ill;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t q[$];
   exp_t snap;
   logic held;
   int   tests, fails;
   int   retired, run, max_run, accepted, stalls;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: checks hold-stability under stall and pops the scoreboard on retire.
   initial begin
      held = 1'b0; retired = 0; run = 0; max_run = 0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            held = 1'b0;
            run  = 0;
         end else begin
            if (held && out_valid)
               chk("stable", 32'({out_result, out_ovf, out_zero, out_illegal, out_tag}), 32'(snap));
            held = out_valid && !out_ready;
            snap = '{out_result, out_ovf, out_zero, out_illegal, out_tag};
            if (out_valid && out_ready) begin
               exp_t e;
               retired++;
               run++;
               if (run > max_run) max_run = run;
               if (q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_result: got tag %0d, expected none", out_tag);
               end else begin
                  e = q.pop_front();
                  chk("result", 32'(out_result), 32'(e.res));
                  chk("ovf", 32'(out_ovf), 32'(e.ovf));
                  chk("zero", 32'(out_zero), 32'(e.zero));
                  chk("illegal", 32'(out_illegal), 32'(e.ill));
                  chk("tag", 32'(out_tag), 32'(e.tag));
               end
            end else begin
               run = 0;
            end
         end
      end
   end

   task automatic send(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic [TAG_W-1:0] t, input logic [15:0] er,
                       input logic eo, input logic ei);
      int budget;
      budget   = 0;
      in_valid = 1'b1; in_func = f; in_a = a; in_b = b; in_tag = t;
      #1;
      while (!in_ready && budget < 50) begin
         @(negedge clk); #1;
         budget++; stalls++;
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL send_timeout: in_ready stuck at 0, required 1 (tag %0d)", t);
      end else begin
         q.push_back('{res: er, ovf: eo, zero: (er == 16'd0), ill: ei, tag: t});
         accepted++;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   int r0;

   initial begin
      tests = 0; fails = 0; accepted = 0; stalls = 0;
      rst_n = 1'b0; in_valid = 1'b0; in_func = '0; in_a = '0; in_b = '0; in_tag = '0;
      out_ready = 1'b1; ovf_clr = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_aluop", 32'(alu_aluop), 32'd0);
      chk("rst_out_result", 32'(out_result), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_sticky", 32'(ovf_sticky), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ADD latency: control word one cycle after accept, result after two.
      send(FN_ADD, 16'h0003, 16'h0004, 4'd5, 16'h0007, 1'b0, 1'b0);
      chk("lat_aluop", 32'(alu_aluop), 32'(5'b00010));
      chk("lat_alu_a", 32'(alu_a), 32'h3);
      chk("lat_alu_b", 32'(alu_b), 32'h4);
      chk("lat_out_valid_early", 32'(out_valid), 32'd0);
      @(negedge clk); #1;
      chk("lat_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);

      // Overflow and sticky flag.
      send(FN_SUB, 16'h7FFF, 16'hFFFF, 4'd1, 16'h8000, 1'b1, 1'b0);
      send(FN_AND, 16'h00F0, 16'h0F00, 4'd2, 16'h0000, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk("sticky_set", 32'(ovf_sticky), 32'd1);
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      #1;
      chk("sticky_clr", 32'(ovf_sticky), 32'd0);
      @(negedge clk);

      send(FN_SLT, 16'hFFFE, 16'h0001, 4'd3, 16'h0001, 1'b0, 1'b0);
      send(FN_NOR, 16'h00FF, 16'h0F00, 4'd4, 16'hF000, 1'b0, 1'b0);
      send(FN_NAND, 16'hFFFF, 16'hFFFF, 4'd6, 16'h0000, 1'b0, 1'b0);
      repeat (3) @(negedge clk);

      // Back-to-back stream with no back-pressure.
      r0 = retired; stalls = 0; max_run = 0;
      for (int i = 0; i < 8; i++)
         send(FN_ADD, 16'(i), 16'h0100, 4'(i), 16'h0100 + 16'(i), 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("stream_stalls", 32'(stalls), 32'd0);
      chk("stream_count", 32'(retired - r0), 32'd8);
      chk("stream_run", 32'(max_run >= 8), 32'd1);

      // Back-pressure: two accepts then in_ready low until the consumer resumes.
      out_ready = 1'b0; accepted = 0; r0 = retired;
      fork
         for (int i = 0; i < 5; i++)
            send(FN_OR, 16'h0A00, 16'(i), 4'(8 + i), 16'h0A00 | 16'(i), 1'b0, 1'b0);
         begin
            repeat (4) @(negedge clk);
            chk("bp_accepts", 32'(accepted), 32'd2);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            out_ready = 1'b1;
         end
      join
      repeat (4) @(negedge clk);
      chk("bp_drained", 32'(q.size()), 32'd0);
      chk("bp_count", 32'(retired - r0), 32'd5);

      send(FN_RSVD, 16'hFFFF, 16'h1234, 4'd3, 16'h1234, 1'b0, 1'b1);
      repeat (3) @(negedge clk);

      // Reset with both stages full discards everything.
      out_ready = 1'b0; r0 = retired;
      send(FN_ADD, 16'h0010, 16'h0020, 4'd7, 16'h0030, 1'b0, 1'b0);
      send(FN_NAND, 16'h00FF, 16'h0F0F, 4'd9, 16'hFFF0, 1'b0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_aluop", 32'(alu_aluop), 32'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_retired", 32'(retired - r0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
